parity_rx: RTL

//   Bit-serial frame receiver with parity checking.

---
 rtl/parity_rx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/parity_rx.sv
// parity_rx
//   Bit-serial frame receiver with parity check. A frame is one start bit
//   (low), DATA_W data bits LSB first, one parity bit and one stop bit (high).
//   The received data bits are XOR-reduced and compared with the parity bit;
//   a low stop bit is reported as a framing error and the FSM then waits in
//   BREAK until the line returns high.
//
// Ports
//   CLK      system clock, rising edge
//   RST      asynchronous active-high reset
//   RXD      serial line, idle high, asynchronous to CLK
//   DATA     last received data word
//   VALID    one-cycle pulse when DATA/PAR_ERR/FRM_ERR are updated
//   PAR_ERR  parity mismatch on the last frame
//   FRM_ERR  stop bit sampled low on the last frame
//   BUSY     high whenever the FSM is not idle
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | line idle, waiting for rxs low
// START  | timing to mid start bit; high there is a false start
// DATA   | sampling DATA_W data bits into the shift register
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, publishing the frame
// BREAK  | stop bit was low; waiting for the line to go high again
module parity_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ODD_PARITY   = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD,
  output logic [DATA_W-1:0] DATA,
  output logic              VALID,
  output logic              PAR_ERR,
  output logic              FRM_ERR,
  output logic              BUSY
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 0) ? $clog2(DATA_W + 1) : 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(1);
  localparam logic             ODD       = (ODD_PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state;
  logic              rx_meta;
  logic              rxs;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              tick;

  // Each new bit enters at the MSB so the first bit ends at bit 0.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                 input logic b);
    logic [DATA_W-1:0] r;
    r = v >> 1;
    r[DATA_W-1] = b;
    return r;
  endfunction

  // Synchroniser resets to the idle line level so reset release cannot
  // look like a start edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RXD;
      rxs     <= rx_meta;
    end
  end

  // Down-counter terminal count marks a sample point.
  assign tick = (cyc_cnt == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      DATA    <= '0;
      VALID   <= 1'b0;
      PAR_ERR <= 1'b0;
      FRM_ERR <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      VALID <= 1'b0;

      // Sample spacing: half a bit to the first sample, then one bit each.
      if (state == S_START || state == S_DATA ||
          state == S_PARITY || state == S_STOP) begin
        if (tick) begin
          cyc_cnt <= FULL_LOAD;
        end else begin
          cyc_cnt <= cyc_cnt - 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state   <= S_START;
            cyc_cnt <= HALF_LOAD;
            bit_cnt <= '0;
            BUSY    <= 1'b1;
          end
        end

        S_START: begin
          if (tick) begin
            if (rxs) begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end else begin
              state   <= S_DATA;
              bit_cnt <= BIT_LOAD;
            end
          end
        end

        S_DATA: begin
          if (tick) begin
            shreg   <= shift_in(shreg, rxs);
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state <= S_PARITY;
            end
          end
        end

        S_PARITY: begin
          if (tick) begin
            par_bit <= rxs;
            state   <= S_STOP;
          end
        end

        S_STOP: begin
          if (tick) begin
            VALID   <= 1'b1;
            DATA    <= shreg;
            PAR_ERR <= ((^shreg) ^ par_bit) != ODD;
            FRM_ERR <= ~rxs;
            if (rxs) begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end else begin
              state <= S_BREAK;
            end
          end
        end

        S_BREAK: begin
          if (rxs) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
